poly_voice_alloc: RTL
=====================

Name: poly_voice_alloc

Overview:
- Polyphonic successor to the single-voice synth path: accepts note-on/note-off events and assigns them to NUM_VOICES voice channels.
- Drives each voice's gate (trig) and oscillator period (osc_count), tracks each voice's lifecycle, and mixes the per-voice samples into one saturated output sample.
- Sits between the SPI/pin event source and an array of per-voice ADSR/oscillator/filter chains, all in the audio clock domain.

Parameters:
- NUM_VOICES, 4: number of voice channels, 2..8.
- COUNT_W, 12: oscillator period width; matches osc_count.
- SAMPLE_W, 8: signed per-voice and mix sample width.
- MIX_SHIFT, 2: arithmetic right shift applied to the voice sum before saturation.

Ports:
- clk  in  1  audio clock, 20.48 MHz.
- rst  in  1  reset, asynchronous, active-high.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accept; transfer occurs when ev_valid & ev_ready.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_count  in  COUNT_W  note identity / oscillator period.
- voice_busy  in  NUM_VOICES  per-voice envelope still non-zero (from ADSR).
- voice_trig  out  NUM_VOICES  per-voice gate, level.
- voice_count  out  NUM_VOICES*COUNT_W  per-voice osc period; voice i at [i*COUNT_W +: COUNT_W].
- voice_sample  in  NUM_VOICES*SAMPLE_W  signed per-voice samples, same packing scheme.
- sample_valid  in  1  strobe; all voice_sample fields are valid in this cycle.
- mix_out  out  SAMPLE_W  signed mixed sample.
- mix_valid  out  1  one-cycle strobe for mix_out.
- active_voices  out  $clog2(NUM_VOICES+1)  count of voices not FREE.

Behaviour:
- Reset (async, rst=1):
  - All voices FREE; voice_trig=0, voice_count=0.
  - Age rank[i]=i (0 = newest, NUM_VOICES-1 = oldest).
  - FSM state IDLE; ev_ready=0 while rst is asserted, 1 from the first clock after deassertion.
  - mix_out=0, mix_valid=0, active_voices=0.
  - Reset asserted mid-operation (including in RETRIG) aborts the pending event; the event is lost.
- Per-voice states:
  - FREE -> HELD on allocation; gate=1.
  - HELD -> RELEASING on matching note-off; gate=0.
  - RELEASING -> FREE when voice_busy[i]=0, sampled every cycle while RELEASING. voice_busy is ignored in other states.
- Event FSM, IDLE (ev_ready=1). On accept, decided in the same cycle:
  - Note-on, ev_count==0: ignored, no state change.
  - Note-on, ev_count matches the count of a HELD or RELEASING voice (lowest index wins): retrigger that voice.
  - Otherwise, the victim is chosen in this order: lowest-index FREE voice; else oldest-rank RELEASING voice; else oldest-rank HELD voice (steal).
  - FREE victim: at the next edge, voice_count=ev_count, gate=1, state HELD; stay in IDLE.
  - Retrigger or steal: at the next edge, gate=0, voice_count=ev_count, go to RETRIG.
  - Note-off: the lowest-index HELD voice with matching count goes to RELEASING, gate=0 at the next edge. No match: ignored.
- RETRIG: ev_ready=0 for exactly one cycle. Next edge: gate=1, state HELD, return to IDLE. This guarantees the ADSR sees a rising gate edge.
- Age update on every allocation, retrigger or steal of voice v: ranks less than rank[v] increment by 1; rank[v]=0. Ranks always form a permutation of 0..NUM_VOICES-1.
- Latency:
  - Plain allocation: gate high 1 cycle after accept.
  - Retrigger/steal: gate low at +1, high at +2; next event acceptable at +2.
- Mixer, on sample_valid:
  - Sum the sign-extended samples of non-FREE voices; FREE voices contribute 0. Sum width is SAMPLE_W+$clog2(NUM_VOICES).
  - Arithmetic shift right by MIX_SHIFT, then saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - mix_out registered; mix_valid=1 exactly one cycle after sample_valid. mix_out holds its value otherwise.
  - Voice state is taken as of the sample_valid cycle, before that cycle's event update.
- active_voices: registered, reflects state after each edge.

Test Plan:
- Reset, then note-on 100, 200, 300 -> voices 0,1,2 gate high one cycle after each accept; voice_count = 100/200/300; active_voices=3.
- With 4 HELD voices (counts 10,20,30,40, allocated in that order), note-on 50 -> voice 0 (oldest) gate 0 at +1, count 50, gate 1 at +2; ev_ready low exactly one cycle.
- Note-off 20 -> voice 1 gate 0, RELEASING. Note-on 60 with no FREE voice -> voice 1 stolen, voice 0 untouched. voice_busy[1]=0 while RELEASING -> FREE, active_voices decrements.
- Note-on 30 while voice 2 is HELD at 30 -> voice 2 retriggers (gate 1,0,1); no other voice changes. Note-off 999 -> no change. Note-on 0 -> ignored.
- Mixer, MIX_SHIFT=0, 4 active voices at +100 each -> mix_out=+127. All at -128 -> -128. Samples +10,-5 with voices 2,3 FREE -> +5. mix_valid one cycle after sample_valid.
- rst asserted during RETRIG -> all gates 0 immediately, ev_ready 0; after release ev_ready=1, ranks 0..3, next note-on lands on voice 0.

Source files
------------

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: assigns note-on/note-off events to NUM_VOICES voice
// channels. It drives a gate and an oscillator period for each voice, keeps
// an age ranking that picks which voice to steal, and mixes the per-voice
// samples into one saturated output sample.
//
// Event handshake: a transfer happens in any cycle where ev_valid and
// ev_ready are both high. ev_ready depends only on internal state and never
// on ev_valid. The source must hold ev_note_on/ev_count stable while
// ev_valid is high and ev_ready is low.
module poly_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int COUNT_W    = 12,
  parameter int SAMPLE_W   = 8,
  parameter int MIX_SHIFT  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_note_on,
  input  logic [COUNT_W-1:0]             ev_count,
  input  logic [NUM_VOICES-1:0]          voice_busy,
  output logic [NUM_VOICES-1:0]          voice_trig,
  output logic [NUM_VOICES*COUNT_W-1:0]  voice_count,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic                           sample_valid,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_valid,
  output logic [$clog2(NUM_VOICES+1)-1:0] active_voices
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACT_W = $clog2(NUM_VOICES + 1);
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_e;
  typedef enum logic {S_IDLE, S_RETRIG} fsm_e;

  fsm_e                  fsm_q, fsm_d;
  logic                  started_q, started_d;
  logic [IDX_W-1:0]      pend_q, pend_d;
  vstate_e               vstate_q [NUM_VOICES];
  vstate_e               vstate_d [NUM_VOICES];
  logic [COUNT_W-1:0]    count_q [NUM_VOICES];
  logic [COUNT_W-1:0]    count_d [NUM_VOICES];
  logic [IDX_W-1:0]      rank_q [NUM_VOICES];
  logic [IDX_W-1:0]      rank_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [ACT_W-1:0]      active_q, active_d;
  logic [SAMPLE_W-1:0]   mix_out_q, mix_out_d;
  logic                  mix_valid_q, mix_valid_d;

  logic                  on_hit, off_hit, free_hit, rel_hit, held_hit;
  logic [IDX_W-1:0]      on_idx, off_idx, free_idx, rel_idx, held_idx;
  logic [IDX_W-1:0]      rel_rank, held_rank;
  logic [IDX_W-1:0]      victim;
  logic                  victim_retrig;
  logic                  accept;
  logic signed [SUM_W-1:0] mix_sum, mix_shift;
  logic [SAMPLE_W-1:0]   mix_sat;

  assign ev_ready      = started_q & (fsm_q == S_IDLE);
  assign accept        = ev_valid & ev_ready;
  assign voice_trig    = trig_q;
  assign active_voices = active_q;
  assign mix_out       = mix_out_q;
  assign mix_valid     = mix_valid_q;

  // Pack per-voice periods onto the flat output bus.
  always_comb begin
    voice_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_count[i*COUNT_W +: COUNT_W] = count_q[i];
    end
  end

  // Candidate search: count matches (lowest index), lowest free voice, and
  // the oldest releasing / held voices; then pick the note-on victim.
  always_comb begin
    on_hit    = 1'b0;
    on_idx    = '0;
    off_hit   = 1'b0;
    off_idx   = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    rel_hit   = 1'b0;
    rel_idx   = '0;
    rel_rank  = '0;
    held_hit  = 1'b0;
    held_idx  = '0;
    held_rank = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vstate_q[i] != V_FREE && count_q[i] == ev_count) begin
        on_hit = 1'b1;
        on_idx = IDX_W'(i);
      end
      if (vstate_q[i] == V_HELD && count_q[i] == ev_count) begin
        off_hit = 1'b1;
        off_idx = IDX_W'(i);
      end
      if (vstate_q[i] == V_FREE) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vstate_q[i] == V_REL && (!rel_hit || rank_q[i] > rel_rank)) begin
        rel_hit  = 1'b1;
        rel_idx  = IDX_W'(i);
        rel_rank = rank_q[i];
      end
      if (vstate_q[i] == V_HELD && (!held_hit || rank_q[i] > held_rank)) begin
        held_hit  = 1'b1;
        held_idx  = IDX_W'(i);
        held_rank = rank_q[i];
      end
    end
    if (on_hit) begin
      victim        = on_idx;
      victim_retrig = 1'b1;
    end else if (free_hit) begin
      victim        = free_idx;
      victim_retrig = 1'b0;
    end else if (rel_hit) begin
      victim        = rel_idx;
      victim_retrig = 1'b1;
    end else begin
      victim        = held_idx;
      victim_retrig = 1'b1;
    end
  end

  // Event FSM and voice lifecycle. A retriggered or stolen voice is marked
  // HELD at accept with its gate low; RETRIG raises the gate one cycle later
  // so the envelope always sees a rising edge.
  always_comb begin
    fsm_d     = fsm_q;
    started_d = 1'b1;
    pend_d    = pend_q;
    vstate_d  = vstate_q;
    count_d   = count_q;
    rank_d    = rank_q;
    trig_d    = trig_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vstate_q[i] == V_REL && !voice_busy[i]) begin
        vstate_d[i] = V_FREE;
      end
    end
    case (fsm_q)
      S_IDLE: begin
        if (accept) begin
          if (ev_note_on) begin
            if (ev_count != '0) begin
              vstate_d[victim] = V_HELD;
              count_d[victim]  = ev_count;
              trig_d[victim]   = ~victim_retrig;
              for (int j = 0; j < NUM_VOICES; j++) begin
                if (rank_q[j] < rank_q[victim]) begin
                  rank_d[j] = rank_q[j] + IDX_W'(1);
                end
              end
              rank_d[victim] = '0;
              if (victim_retrig) begin
                fsm_d  = S_RETRIG;
                pend_d = victim;
              end
            end
          end else if (off_hit) begin
            vstate_d[off_idx] = V_REL;
            trig_d[off_idx]   = 1'b0;
          end
        end
      end
      S_RETRIG: begin
        trig_d[pend_q] = 1'b1;
        fsm_d          = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Count voices that will be non-free after this edge.
  always_comb begin
    active_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vstate_d[i] != V_FREE) active_d = active_d + ACT_W'(1);
    end
  end

  // Mixer: sum live voices, shift, saturate; capture on sample_valid.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (vstate_q[i] != V_FREE) begin
        mix_sum = mix_sum + {{(SUM_W-SAMPLE_W){voice_sample[i*SAMPLE_W+SAMPLE_W-1]}},
                             voice_sample[i*SAMPLE_W +: SAMPLE_W]};
      end
    end
    mix_shift = mix_sum >>> MIX_SHIFT;
    if (mix_shift > SAT_MAX)      mix_sat = SAT_MAX[SAMPLE_W-1:0];
    else if (mix_shift < SAT_MIN) mix_sat = SAT_MIN[SAMPLE_W-1:0];
    else                          mix_sat = mix_shift[SAMPLE_W-1:0];
    mix_out_d   = sample_valid ? mix_sat : mix_out_q;
    mix_valid_d = sample_valid;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      started_q   <= 1'b0;
      pend_q      <= '0;
      trig_q      <= '0;
      active_q    <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= V_FREE;
        count_q[i]  <= '0;
        rank_q[i]   <= IDX_W'(i);
      end
    end else begin
      fsm_q       <= fsm_d;
      started_q   <= started_d;
      pend_q      <= pend_d;
      trig_q      <= trig_d;
      active_q    <= active_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= vstate_d[i];
        count_q[i]  <= count_d[i];
        rank_q[i]   <= rank_d[i];
      end
    end
  end

endmodule
